// File: rtl/dyser_input_port_pkg.sv
// Types and constants shared by the DySER input port, its FIFO and its bench.
// The guarded defines mirror config.sv so the package elaborates on its own.
`ifndef PATH_WIDTH
`define PATH_WIDTH 16
`endif
`ifndef DYSER_IP_IDLE
`define DYSER_IP_IDLE 2'd0
`endif
`ifndef DYSER_IP_SEND
`define DYSER_IP_SEND 2'd1
`endif
`ifndef DYSER_IP_STARVED
`define DYSER_IP_STARVED 2'd2
`endif

package dyser_input_port_pkg;

  localparam int PATH_W = `PATH_WIDTH;

  typedef enum logic [1:0] {
    IP_IDLE    = `DYSER_IP_IDLE,
    IP_SEND    = `DYSER_IP_SEND,
    IP_STARVED = `DYSER_IP_STARVED
  } ip_state_e;

  // State implied by the post-edge FIFO occupancy and credit count.
  function automatic ip_state_e ip_state_for(input logic fifo_nonempty,
                                             input logic have_credit);
    if (!fifo_nonempty) return IP_IDLE;
    if (have_credit)    return IP_SEND;
    return IP_STARVED;
  endfunction

endpackage

// File: rtl/config.sv
// Shared fabric-wide defines: datapath width and the input-port FSM encodings
// used by the port, its bench and any fabric wrapper.
`ifndef PATH_WIDTH
`define PATH_WIDTH 16
`endif
`ifndef DYSER_IP_IDLE
`define DYSER_IP_IDLE 2'd0
`endif
`ifndef DYSER_IP_SEND
`define DYSER_IP_SEND 2'd1
`endif
`ifndef DYSER_IP_STARVED
`define DYSER_IP_STARVED 2'd2
`endif

// File: rtl/dyser_sync_fifo.sv
// Single-clock FIFO with registered count; pointers wrap modulo DEPTH
// (DEPTH is a power of two). Push when full and pop when empty are ignored.
module dyser_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the count guards every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/dyser_input_port.sv
// Credit-based DySER fabric input port: buffers host words and issues one
// single-cycle token per held credit to the first switch stage.
module dyser_input_port
  import dyser_input_port_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int INIT_CREDITS = 1,
  parameter int MAX_CREDITS  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [PATH_W-1:0]              in_data,
  output logic                           in_ready,
  input  logic                           credit_in,
  output logic                           valid_out,
  output logic [PATH_W-1:0]              data_out,
  output logic [$clog2(DEPTH):0]         fifo_count,
  output logic [$clog2(MAX_CREDITS):0]   credits,
  output logic                           starved,
  output logic                           err_credit
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CR_W  = $clog2(MAX_CREDITS) + 1;

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [PATH_W-1:0] head;
  logic              full, empty;
  logic              push, send;

  logic [CR_W-1:0]   credits_q, credits_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic [PATH_W-1:0] data_q, data_d;
  ip_state_e         state_q, state_d;

  // in_ready depends only on the registered count; a full FIFO never accepts
  // a word even on a cycle where it also pops.
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign send     = !empty && (credits_q != '0);

  dyser_sync_fifo #(
    .WIDTH (PATH_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (in_data),
    .pop_i       (send),
    .head_o      (head),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  // A returned credit at the ceiling with nothing spent saturates and flags.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    unique case ({credit_in, send})
      2'b10: begin
        if (credits_q == CR_W'(MAX_CREDITS)) err_d = 1'b1;
        else                                 credits_d = credits_q + CR_W'(1);
      end
      2'b01:   credits_d = credits_q - CR_W'(1);
      default: credits_d = credits_q;
    endcase
  end

  always_comb begin
    count_next = count;
    if (push && !send)      count_next = count + CNT_W'(1);
    else if (!push && send) count_next = count - CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IP_IDLE: begin
        if (count_next != '0) state_d = ip_state_for(1'b1, credits_d != '0);
      end
      IP_SEND: begin
        if (count_next == '0)      state_d = IP_IDLE;
        else if (credits_d == '0)  state_d = IP_STARVED;
      end
      IP_STARVED: begin
        if (count_next == '0)      state_d = IP_IDLE;
        else if (credits_d != '0)  state_d = IP_SEND;
      end
      default: state_d = IP_IDLE;
    endcase
  end

  always_comb begin
    valid_d = send;
    data_d  = send ? head : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits_q <= CR_W'(INIT_CREDITS);
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      state_q   <= IP_IDLE;
    end else begin
      credits_q <= credits_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      state_q   <= state_d;
    end
  end

  assign valid_out  = valid_q;
  assign data_out   = data_q;
  assign fifo_count = count;
  assign credits    = credits_q;
  assign starved    = (state_q == IP_STARVED);
  assign err_credit = err_q;

endmodule

// File: tb/tb_dyser_input_port.sv
// Scoreboard bench for dyser_input_port: a cycle model predicts every output
// and a queue of accepted host words supplies the expected token data.
module tb_dyser_input_port;
  import dyser_input_port_pkg::*;

  localparam int DEPTH = 4;
  localparam int INIT  = 1;
  localparam int MAX   = 2;
  localparam int W     = PATH_W;

  logic                         clk;
  logic                         rst_n;
  logic                         in_valid;
  logic [W-1:0]                 in_data;
  logic                         in_ready;
  logic                         credit_in;
  logic                         valid_out;
  logic [W-1:0]                 data_out;
  logic [$clog2(DEPTH):0]       fifo_count;
  logic [$clog2(MAX):0]         credits;
  logic                         starved;
  logic                         err_credit;

  dyser_input_port #(
    .DEPTH        (DEPTH),
    .INIT_CREDITS (INIT),
    .MAX_CREDITS  (MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .credit_in  (credit_in),
    .valid_out  (valid_out),
    .data_out   (data_out),
    .fifo_count (fifo_count),
    .credits    (credits),
    .starved    (starved),
    .err_credit (err_credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int           m_count;
  int           m_credits;
  bit           m_err;
  bit           m_starved;
  bit           m_valid;
  logic [W-1:0] m_data;
  logic [W-1:0] sb [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count   = 0;
    m_credits = INIT;
    m_err     = 1'b0;
    m_starved = 1'b0;
    m_valid   = 1'b0;
    m_data    = '0;
    sb.delete();
  endtask

  task automatic check_outputs();
    check("valid_out",  32'(valid_out),  32'(m_valid));
    check("data_out",   32'(data_out),   32'(m_data));
    check("fifo_count", 32'(fifo_count), 32'(m_count));
    check("credits",    32'(credits),    32'(m_credits));
    check("starved",    32'(starved),    32'(m_starved));
    check("err_credit", 32'(err_credit), 32'(m_err));
    check("in_ready",   32'(in_ready),   32'(m_count != DEPTH));
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit c, output bit acc);
    bit           push, send;
    logic [W-1:0] exp_word;
    in_valid  = v;
    in_data   = d;
    credit_in = c;
    push = v && (m_count != DEPTH);
    send = (m_count != 0) && (m_credits != 0);
    exp_word = m_data;
    if (send) exp_word = sb.pop_front();
    if (push) sb.push_back(d);
    if (c && !send) begin
      if (m_credits == MAX) m_err = 1'b1;
      else                  m_credits++;
    end else if (!c && send) begin
      m_credits--;
    end
    m_count   = m_count + int'(push) - int'(send);
    m_starved = (m_count != 0) && (m_credits == 0);
    m_valid   = send;
    m_data    = exp_word;
    acc       = push;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, acc);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_data   = '0;
    credit_in = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit acc;
    bit pend;
    model_reset();
    do_reset();

    // Single word: accepted at one edge, token strobes after the next only.
    idle(1);
    cycle(1'b1, W'(16'h00A5), 1'b0, acc);
    idle(3);

    // Credit stall: restore one credit, word 2 waits starved until credit returns.
    cycle(1'b0, '0, 1'b1, acc);
    cycle(1'b1, W'(16'h0001), 1'b0, acc);
    cycle(1'b1, W'(16'h0002), 1'b0, acc);
    idle(3);
    cycle(1'b0, '0, 1'b1, acc);
    idle(2);

    // Full FIFO with no credits: fifth word is held off by in_ready.
    for (int k = 1; k <= 4; k++) cycle(1'b1, W'(k), 1'b0, acc);
    cycle(1'b1, W'(5), 1'b0, acc);
    cycle(1'b1, W'(5), 1'b0, acc);
    pend = 1'b1;
    for (int i = 0; i < 24 && (pend || sb.size() != 0); i++) begin
      cycle(pend, W'(5), (i % 2) == 0, acc);
      if (acc) pend = 1'b0;
    end
    check("drain_t3", 32'(sb.size()), 32'd0);
    idle(1);

    // Simultaneous credit and send, then back-to-back tokens.
    for (int i = 0; i < 4 && m_credits == 0; i++) cycle(1'b0, '0, 1'b1, acc);
    cycle(1'b1, W'(16'h0100), 1'b0, acc);
    for (int k = 1; k <= 6; k++) cycle(1'b1, W'(16'h0100 + k), 1'b1, acc);
    cycle(1'b0, '0, 1'b1, acc);
    idle(2);

    // Overflow: credits pinned at MAX, sticky error.
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, acc);
    idle(2);

    // Reset mid-stream with three buffered words and a token on the wire.
    do_reset();
    cycle(1'b1, W'(16'h0A01), 1'b0, acc);
    cycle(1'b1, W'(16'h0A02), 1'b0, acc);
    cycle(1'b1, W'(16'h0A03), 1'b0, acc);
    cycle(1'b1, W'(16'h0A04), 1'b0, acc);
    cycle(1'b1, W'(16'h0A05), 1'b1, acc);
    cycle(1'b0, '0, 1'b0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    cycle(1'b1, W'(16'h0BEE), 1'b0, acc);
    idle(3);
    check("drain_end", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
